// File: rtl/muldiv_pkg.sv
// Shared encodings and op-class decoders for the iterative M-extension unit.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int WORD_ITERS = 32;

    function automatic logic is_word(input logic [3:0] op);
        return (op >= OP_MULW) && (op <= OP_REMUW);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_REMUW;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return ((op >= OP_DIV) && (op <= OP_REMU)) || ((op >= OP_DIVW) && (op <= OP_REMUW));
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
    endfunction

    function automatic logic is_signed_a(input logic [3:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM)
            || (op == OP_DIVW) || (op == OP_REMW);
    endfunction

    function automatic logic is_signed_b(input logic [3:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM)
            || (op == OP_DIVW) || (op == OP_REMW);
    endfunction

endpackage

// File: rtl/muldiv_prep.sv
// Operand preparation shared by multiply and divide: extension, magnitude/sign
// split, and detection of ops whose result is known without iterating.
module muldiv_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit WORD_OPS = 1
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg,
    output logic            special,
    output logic [XLEN-1:0] special_res
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] x, input logic word);
        logic [XLEN-1:0] r;
        if (word) r = XLEN'($signed(x[31:0]));
        else      r = x;
        return r;
    endfunction

    logic            word;
    logic            illegal;
    logic            a_neg;
    logic            b_neg;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;

    always_comb begin
        word    = is_word(op);
        illegal = is_illegal(op) || (word && !WORD_OPS);

        a_ext = rs1;
        b_ext = rs2;
        if (word) begin
            if (is_signed_a(op)) a_ext = XLEN'($signed(rs1[31:0]));
            else                 a_ext = XLEN'(rs1[31:0]);
            if (is_signed_b(op)) b_ext = XLEN'($signed(rs2[31:0]));
            else                 b_ext = XLEN'(rs2[31:0]);
        end

        a_neg = is_signed_a(op) && a_ext[XLEN-1];
        b_neg = is_signed_b(op) && b_ext[XLEN-1];
        mag_a = a_neg ? -a_ext : a_ext;
        mag_b = b_neg ? -b_ext : b_ext;
        neg   = is_rem(op) ? a_neg : (a_neg ^ b_neg);

        div0 = (b_ext == '0);
        // Overflow is judged on the 32-bit values for word forms.
        if (word) ovf = (rs1[31:0] == 32'h8000_0000) && (rs2[31:0] == 32'hFFFF_FFFF);
        else      ovf = (rs1 == MOST_NEG) && (rs2 == '1);
        ovf = ovf && is_signed_a(op);

        special     = illegal || (is_div(op) && (div0 || ovf));
        special_res = '0;
        if (!illegal && div0)     special_res = is_rem(op) ? fit(rs1, word) : '1;
        else if (!illegal && ovf) special_res = is_rem(op) ? '0 : fit(rs1, word);
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one product or quotient bit per clock,
// valid/ready handshakes on both sides.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter bit WORD_OPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    state_e          state;
    logic [CW-1:0]   iter;
    logic [3:0]      cur_op;
    logic            cur_neg;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd_b;

    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic              load;
    logic [CW-1:0]     last_iter;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   nxt_hi;
    logic [XLEN-1:0]   nxt_lo;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   dv;
    logic [XLEN-1:0]   final_res;

    muldiv_prep #(
        .XLEN    (XLEN),
        .WORD_OPS(WORD_OPS)
    ) u_prep (
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .neg        (neg),
        .special    (special),
        .special_res(special_res)
    );

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign load     = (state == S_IDLE) && in_valid && !flush && !special;

    always_comb begin
        last_iter = is_word(cur_op) ? CW'(WORD_ITERS - 1) : CW'(XLEN - 1);

        // Multiply: add-and-shift-right; divide: shift-left-and-restore.
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_b});
        div_diff  = div_shift[XLEN-1:0] - opnd_b;
        if (is_div(cur_op)) begin
            nxt_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end

        prod = {nxt_hi, nxt_lo};
        if (cur_neg) prod = -prod;
        dv = is_rem(cur_op) ? nxt_hi : nxt_lo;
        if (cur_neg) dv = -dv;

        // A 32-iteration word multiply leaves its low product bits at the top of acc_lo.
        if (is_div(cur_op)) begin
            if (is_word(cur_op)) final_res = XLEN'($signed(dv[31:0]));
            else                 final_res = dv;
        end else if (is_word(cur_op)) begin
            final_res = XLEN'($signed(nxt_lo[XLEN-1 -: 32]));
        end else if (cur_op == OP_MUL) begin
            final_res = prod[XLEN-1:0];
        end else begin
            final_res = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            cur_op  <= op;
            cur_neg <= neg;
            acc_hi  <= '0;
            if (is_div(op)) begin
                acc_lo <= is_word(op) ? (mag_a << (XLEN - WORD_ITERS)) : mag_a;
                opnd_b <= mag_b;
            end else begin
                acc_lo <= mag_b;
                opnd_b <= mag_a;
            end
        end else if (state == S_CALC) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            iter      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        iter <= '0;
                        if (special) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (iter == last_iter) begin
                        result    <= final_res;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        iter <= iter + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed vector bench for muldiv_iter (XLEN=64, word ops enabled).
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int XLEN = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      op = 4'd0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(XLEN), .WORD_OPS(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rs1      (rs1),
        .rs2      (rs2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op       = o;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'd15;
        rs1      = ~a;
        rs2      = ~b;
    endtask

    // Latency counts the handshake cycle as 1.
    task automatic wait_result(output logic [63:0] res, output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] res;
        int          lat;
        int          bad;

        vecs.push_back('{"mul_neg",    OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65});
        vecs.push_back('{"mulhu_max",  OP_MULHU,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65});
        vecs.push_back('{"mulhsu",     OP_MULHSU, ONES, 64'd2, ONES, 65});
        vecs.push_back('{"mulh_neg",   OP_MULH,   64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, 65});
        vecs.push_back('{"mulh_pos",   OP_MULH,   64'h4000_0000_0000_0000, 64'd8, 64'd2, 65});
        vecs.push_back('{"div_neg",    OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
        vecs.push_back('{"rem_neg",    OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65});
        vecs.push_back('{"div_negb",   OP_DIV,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65});
        vecs.push_back('{"rem_negb",   OP_REM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65});
        vecs.push_back('{"divu",       OP_DIVU,   64'd1000, 64'd7, 64'd142, 65});
        vecs.push_back('{"remu",       OP_REMU,   64'd1000, 64'd7, 64'd6, 65});
        vecs.push_back('{"divu_zero",  OP_DIVU,   64'd100, 64'd0, ONES, 1});
        vecs.push_back('{"remu_zero",  OP_REMU,   64'd100, 64'd0, 64'd100, 1});
        vecs.push_back('{"div_ovf",    OP_DIV,    64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1});
        vecs.push_back('{"rem_ovf",    OP_REM,    64'h8000_0000_0000_0000, ONES, 64'd0, 1});
        vecs.push_back('{"divw_ovf",   OP_DIVW,   64'h1_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1});
        vecs.push_back('{"remw_ovf",   OP_REMW,   64'h1_8000_0000, ONES, 64'd0, 1});
        vecs.push_back('{"mulw",       OP_MULW,   64'h1_0001_0000, 64'h8000, 64'hFFFF_FFFF_8000_0000, 33});
        vecs.push_back('{"divuw",      OP_DIVUW,  64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 64'h0FFF_FFFF, 33});
        vecs.push_back('{"remw_neg",   OP_REMW,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 33});
        vecs.push_back('{"divw_zero",  OP_DIVW,   64'h8000_0005, 64'd0, ONES, 1});
        vecs.push_back('{"remuw_zero", OP_REMUW,  64'h8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1});
        vecs.push_back('{"illegal13",  4'd13,     64'd5, 64'd3, 64'd0, 1});
        vecs.push_back('{"illegal15",  4'd15,     ONES, ONES, 64'd0, 1});
        vecs.push_back('{"mul_small",  OP_MUL,    64'd3, 64'd5, 64'd15, 65});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    result,         64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        foreach (vecs[i]) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(res, lat);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            drain();
        end

        // Consumer stall: result held, no new request taken.
        start_op(OP_MUL, 64'd3, 64'd5);
        wait_result(res, lat);
        check("stall_res", res, 64'd15);
        @(negedge clk);
        in_valid = 1'b1;
        op       = OP_DIVU;
        rs1      = 64'd9;
        rs2      = 64'd3;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (result != 64'd15 || !out_valid || in_ready) bad++;
        end
        check("stall_hold", 64'(bad), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        check("stall_release_ready", 64'(in_ready),  64'd1);
        check("stall_release_valid", 64'(out_valid), 64'd0);
        start_op(OP_DIVU, 64'd1000, 64'd7);
        wait_result(res, lat);
        check("after_stall_res", res, 64'd142);
        drain();

        // Flush mid-divide.
        start_op(OP_DIVU, 64'd100, 64'd3);
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy",     64'(busy),     64'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        check("flush_no_valid", 64'(bad), 64'd0);
        start_op(OP_MUL, 64'd3, 64'd5);
        wait_result(res, lat);
        check("flush_next_res", res, 64'd15);
        check("flush_next_lat", 64'(lat), 64'd65);
        drain();

        // Flush wins over a same-cycle request.
        @(negedge clk);
        in_valid = 1'b1;
        op       = OP_MUL;
        rs1      = 64'd2;
        rs2      = 64'd2;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_beats_hs_busy", 64'(busy), 64'd0);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        check("flush_beats_hs_valid", 64'(bad), 64'd0);

        // Reset mid-operation (result currently holds 15).
        start_op(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result",    result,         64'd0);
        check("midrst_busy",      64'(busy),      64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        start_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_result(res, lat);
        check("midrst_next_res", res, ONES);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
